// File: rtl/swm_cfg_loader_pkg.sv
// Shared types and constants for the switch-matrix configuration loader.
// Entries are {index[2:0], side[2:0]} packed into six bits.
package swm_pkg;

    localparam int NUM_TB = 5;
    localparam int NUM_LR = 4;
    localparam int CFG_W  = 6;
    localparam int N_ENT  = 2 * NUM_TB + 2 * NUM_LR;
    localparam int FLAT_W = N_ENT * CFG_W;
    localparam int CNT_W  = 5;

    localparam logic [7:0]       SYNC     = 8'hA5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ENT - 1);

    // Entry base offsets within the flat routing bus, in entry units
    localparam int TOP_BASE   = 0;
    localparam int BOT_BASE   = TOP_BASE + NUM_TB;
    localparam int LEFT_BASE  = BOT_BASE + NUM_TB;
    localparam int RIGHT_BASE = LEFT_BASE + NUM_LR;

    typedef enum logic [2:0] {
        SIDE_NONE   = 3'd0,
        SIDE_TOP    = 3'd1,
        SIDE_RIGHT  = 3'd2,
        SIDE_BOTTOM = 3'd3,
        SIDE_LEFT   = 3'd4
    } side_e;

    typedef struct packed {
        logic [2:0] index;
        logic [2:0] side;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CSUM,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/swm_cfg_loader_if.sv
// Byte-wide valid/ready configuration stream.
interface swm_cfg_loader_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/swm_cfg_loader_entry_check.sv
// Combinational legality check of one routing-entry byte at payload slot cnt.
// Kept standalone so a readback path can reuse the same rules.
module swm_entry_check
    import swm_pkg::*;
(
    input  logic [7:0]       data,
    input  logic [CNT_W-1:0] cnt,
    output logic             legal
);

    entry_t entry;
    assign entry = entry_t'(data[5:0]);

    always_comb begin
        legal = 1'b1;
        if (data[7:6] != 2'b00) begin
            legal = 1'b0;
        end
        case (side_e'(entry.side))
            SIDE_NONE: ;
            SIDE_TOP, SIDE_BOTTOM: begin
                if (entry.index >= 3'(NUM_TB)) legal = 1'b0;
            end
            SIDE_RIGHT, SIDE_LEFT: begin
                if (entry.index >= 3'(NUM_LR)) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        // A slot number past the last entry can only come from a readback misuse
        if (cnt > LAST_CNT) begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/swm_cfg_loader.sv
// Frame loader: SYNC, 18 entry bytes, XOR checksum; commits all entries
// atomically to the matrix select bus only when the whole frame is good.
module swm_cfg_loader
    import swm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    swm_cfg_loader_if.slave   s,
    input  logic              abort,
    output logic [FLAT_W-1:0] cfg_flat,
    output logic              cfg_update,
    output logic              cfg_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    state_e            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [7:0]        csum_reg;
    logic              bad_reg;
    logic [FLAT_W-1:0] cfg_flat_reg;
    logic              cfg_update_reg;
    logic              cfg_err_reg;
    logic [7:0]        err_count_reg;

    logic [CFG_W-1:0]  shadow_reg [N_ENT];
    logic [FLAT_W-1:0] shadow_flat;
    logic              xfer;
    logic              entry_legal;

    assign s.s_ready  = (state_reg != ST_COMMIT);
    assign xfer       = s.s_valid && s.s_ready;
    assign busy       = (state_reg != ST_IDLE);
    assign cfg_flat   = cfg_flat_reg;
    assign cfg_update = cfg_update_reg;
    assign cfg_err    = cfg_err_reg;
    assign err_count  = err_count_reg;

    swm_entry_check u_check (
        .data  (s.s_data),
        .cnt   (cnt_reg),
        .legal (entry_legal)
    );

    // One shadow register per entry; only the slot addressed by cnt loads
    generate
        for (genvar gi = 0; gi < N_ENT; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= '0;
                end else if (!abort && state_reg == ST_PAYLOAD && xfer
                             && cnt_reg == CNT_W'(gi)) begin
                    shadow_reg[gi] <= s.s_data[CFG_W-1:0];
                end
            end
            assign shadow_flat[gi*CFG_W +: CFG_W] = shadow_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            csum_reg       <= '0;
            bad_reg        <= 1'b0;
            cfg_flat_reg   <= '0;
            cfg_update_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            cfg_update_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
            if (abort) begin
                // Abort wins even over a commit: the frame simply never happened
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                csum_reg  <= '0;
                bad_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (xfer && s.s_data == SYNC) begin
                            state_reg <= ST_PAYLOAD;
                            cnt_reg   <= '0;
                            csum_reg  <= '0;
                            bad_reg   <= 1'b0;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (xfer) begin
                            csum_reg <= csum_reg ^ s.s_data;
                            bad_reg  <= bad_reg | ~entry_legal;
                            if (cnt_reg == LAST_CNT) begin
                                state_reg <= ST_CSUM;
                            end else begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (xfer) begin
                            bad_reg   <= bad_reg | (s.s_data != csum_reg);
                            state_reg <= ST_COMMIT;
                        end
                    end
                    ST_COMMIT: begin
                        if (bad_reg) begin
                            cfg_err_reg <= 1'b1;
                            if (err_count_reg != 8'hFF) begin
                                err_count_reg <= err_count_reg + 1'b1;
                            end
                        end else begin
                            cfg_flat_reg   <= shadow_flat;
                            cfg_update_reg <= 1'b1;
                        end
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_swm_cfg_loader.sv
// Directed bench for swm_cfg_loader: good, bad, aborted, throttled and reset frames.
module tb_swm_cfg_loader;
    import swm_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic [107:0] cfg_flat;
    logic         cfg_update;
    logic         cfg_err;
    logic         busy;
    logic [7:0]   err_count;

    swm_cfg_loader_if bus ();

    swm_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (bus),
        .abort      (abort),
        .cfg_flat   (cfg_flat),
        .cfg_update (cfg_update),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int upd_seen = 0;
    int err_seen = 0;
    int upd_before;
    int err_before;

    logic [7:0]   ent [18];
    logic [7:0]   csum_byte;
    logic [107:0] flat_good;
    logic [107:0] flat_abort;

    always @(posedge clk) begin
        if (cfg_update) upd_seen <= upd_seen + 1;
        if (cfg_err)    err_seen <= err_seen + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!bus.s_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: observed s_ready=0 for %0d cycles, expected 1", t);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic clear_ent();
        for (int i = 0; i < 18; i++) ent[i] = 8'h00;
    endtask

    task automatic send_frame(input bit throttle);
        send_byte(8'hA5, 0);
        for (int i = 0; i < 18; i++)
            send_byte(ent[i], throttle ? int'($urandom_range(0, 2)) : 0);
        send_byte(csum_byte, throttle ? 1 : 0);
    endtask

    // Called right after the checksum edge E (+1): checks COMMIT, the pulse after E+1 and its end
    task automatic check_commit(input string tag, input logic upd, input logic err,
                                input logic [107:0] flat, input logic [7:0] ec);
        chk({tag, "_ready_in_commit"}, {127'd0, bus.s_ready}, 128'd0);
        @(posedge clk);
        #1;
        chk({tag, "_update"}, {127'd0, cfg_update}, {127'd0, upd});
        chk({tag, "_err"}, {127'd0, cfg_err}, {127'd0, err});
        chk({tag, "_flat"}, {20'd0, cfg_flat}, {20'd0, flat});
        chk({tag, "_err_count"}, {120'd0, err_count}, {120'd0, ec});
        chk({tag, "_busy_done"}, {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, {126'd0, cfg_update, cfg_err}, 128'd0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        flat_good   = 108'h14 | (108'h0B << 60);
        flat_abort  = 108'h19 << 102;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_flat", {20'd0, cfg_flat}, 128'd0);
        chk("reset_ready", {127'd0, bus.s_ready}, 128'd1);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_err_count", {120'd0, err_count}, 128'd0);
        chk("reset_pulses", {126'd0, cfg_update, cfg_err}, 128'd0);

        // All-zero frame
        clear_ent();
        csum_byte = 8'h00;
        send_frame(0);
        check_commit("zero", 1'b1, 1'b0, 108'd0, 8'd0);

        // top[0] <- left[2], left[0] <- bottom[1]
        clear_ent();
        ent[0] = 8'h14;
        ent[10] = 8'h0B;
        csum_byte = 8'h1F;
        send_frame(0);
        check_commit("good", 1'b1, 1'b0, flat_good, 8'd0);

        csum_byte = 8'h1E;
        send_frame(0);
        check_commit("bad_csum", 1'b0, 1'b1, flat_good, 8'd1);

        clear_ent();
        ent[3] = 8'h25;
        csum_byte = 8'h25;
        send_frame(0);
        check_commit("side5", 1'b0, 1'b1, flat_good, 8'd2);

        clear_ent();
        ent[7] = 8'h2A;
        csum_byte = 8'h2A;
        send_frame(0);
        check_commit("right_idx5", 1'b0, 1'b1, flat_good, 8'd3);

        // Abort after the 9th payload byte, simultaneous with a 10th byte
        clear_ent();
        upd_before = upd_seen;
        err_before = err_seen;
        send_byte(8'hA5, 0);
        for (int i = 0; i < 9; i++) send_byte(8'h0B, 0);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        bus.s_valid = 1'b0;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_update", 128'(upd_seen - upd_before), 128'd0);
        chk("abort_no_err", 128'(err_seen - err_before), 128'd0);
        chk("abort_flat", {20'd0, cfg_flat}, {20'd0, flat_good});
        ent[17] = 8'h19;
        csum_byte = 8'h19;
        send_frame(0);
        check_commit("after_abort", 1'b1, 1'b0, flat_abort, 8'd3);

        // Throttled good frame
        clear_ent();
        ent[0] = 8'h14;
        ent[10] = 8'h0B;
        csum_byte = 8'h1F;
        send_frame(1);
        check_commit("throttled", 1'b1, 1'b0, flat_good, 8'd3);

        // Reset in the middle of a payload
        send_byte(8'hA5, 0);
        for (int i = 0; i < 5; i++) send_byte(8'h0B, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_flat", {20'd0, cfg_flat}, 128'd0);
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_err_count", {120'd0, err_count}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {127'd0, bus.s_ready}, 128'd1);

        // Error counter saturation
        clear_ent();
        csum_byte = 8'h01;
        for (int f = 0; f < 255; f++) send_frame(0);
        repeat (3) @(negedge clk);
        chk("sat_255", {120'd0, err_count}, 128'd255);
        for (int f = 0; f < 5; f++) send_frame(0);
        repeat (3) @(negedge clk);
        chk("sat_260", {120'd0, err_count}, 128'd255);
        chk("sat_flat", {20'd0, cfg_flat}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
